banner_scan_ctrl: RTL and testbench
===================================

// Module: banner_scan_ctrl
// PURPOSE
//  Sequences the 41-row x 1440-bit banner bitmap ROM for the VGA renderer. Once per
//  scanline it fetches the ROM row for the upcoming line into a row buffer. It then
//  streams one registered pixel bit per clock inside a display window. A per-frame
//  offset counter scrolls the banner horizontally with wrap-around.
//  Sits between the VGA timing generator and the pixel colour mux.
// PARAMETERS
//  WIN_X     100   first visible column of the banner window (pixels)
//  WIN_Y     40    first visible line of the banner window (pixels)
//  WIN_W     640   window width in pixels; legal range 1..1440
//  SCALE_SH  1     vertical scale = 2**SCALE_SH screen lines per ROM row
//  ROW_BITS  1440  ROM row width; bit ROW_BITS-1 is the leftmost pixel
// PORTS
//  clk         in   1     pixel clock
//  rst_n       in   1     asynchronous active-low reset
//  line_start  in   1     1-cycle pulse in h-blank, before each line
//  line_y      in   11    y of the line about to be drawn; valid with line_start
//  frame_start in   1     1-cycle pulse once per frame, in v-blank
//  de          in   1     display enable from timing generator
//  pix_x       in   11    current column, valid while de=1
//  scroll_en   in   1     1 = advance scroll offset at each frame_start
//  speed       in   4     pixels per frame to advance; 0 = frozen
//  scroll_clr  in   1     synchronous clear of the scroll offset
//  rom_data    in   1440  row data from ROM (combinational, settles in 1 cycle)
//  rom_addr    out  6     ROM row address; 1..41 when active
//  pixel_on    out  1     banner pixel is lit (registered, 1-cycle latency)
//  in_window   out  1     pixel is inside the banner window (aligned with pixel_on)
//  scroll_pos  out  11    current scroll offset, 0..1439
//  busy        out  1     row fetch in progress
// BEHAVIOUR
//  Reset: rom_addr=0, pixel_on=0, in_window=0, scroll_pos=0, busy=0.
//   Internal: row_buf=0, row_valid=0, FSM=IDLE.
//  Row-fetch FSM (IDLE -> FETCH -> LATCH -> IDLE):
//   IDLE, line_start with r=(line_y-WIN_Y)>>SCALE_SH in 0..40 and line_y>=WIN_Y:
//    set rom_addr=r+1, row_valid=0, busy=1; go to FETCH.
//   IDLE, line_start with the line outside the rows:
//    row_valid=0, rom_addr=0; stay in IDLE.
//   FETCH: wait 1 cycle for ROM settle; go to LATCH.
//   LATCH: row_buf<=rom_data, row_valid=1, busy=0; go to IDLE.
//   line_start in FETCH or LATCH: abort the current fetch and restart from the
//    IDLE decision with the new line_y. The new line wins.
//  Pixel path, 1-cycle registered latency:
//   win = de && pix_x>=WIN_X && pix_x<WIN_X+WIN_W; in_window<=win.
//   col = pix_x-WIN_X; s = col+scroll_pos (12 bits).
//   If s>=ROW_BITS, subtract ROW_BITS. Single subtract suffices because sum<2880.
//   pixel_on <= win && row_valid && row_buf[ROW_BITS-1-s].
//  Scroll counter, priority order:
//   scroll_clr -> 0.
//   else if frame_start && scroll_en: p=scroll_pos+speed;
//    if p>=ROW_BITS, p -= ROW_BITS.
//   else hold.
//  Simultaneous events:
//   frame_start and line_start in the same cycle are both handled independently.
//   The new offset applies from the next cycle.
//   Changing speed mid-frame takes effect at the next frame_start only.
//  Reset asserted mid-fetch: immediate return to reset values.
//   No partial row_buf update is visible afterwards.
// TESTING
//  1. Reset with rst_n=0 mid-FETCH -> all outputs 0. After release, pixel_on=0
//     until the first full fetch completes.
//  2. line_start, line_y=40 (SCALE_SH=1) -> rom_addr=1 next cycle, busy=1 for
//     2 cycles. row_buf equals ROM row 1. line_y=121 -> rom_addr=41.
//     line_y=122 -> rom_addr=0, pixel_on stays 0.
//  3. ROM row 2 pattern 0x0001C18..., scroll_pos=0, de sweep over pix_x=100..739
//     -> pixel_on matches row_buf bit 1439-(pix_x-100), 1 cycle later.
//     in_window=0 at pix_x=99 and pix_x=740.
//  4. speed=15, scroll_en=1, 96 frame_start pulses ->
//     scroll_pos = 1440 mod 1440 = 0.
//     scroll_pos=1435 with speed=7 -> 2. speed=0 -> holds.
//  5. scroll_clr and frame_start in the same cycle -> scroll_pos=0.
//     scroll_en=0 -> no change over 10 frames.
//  6. line_start re-pulsed 1 cycle after the first -> rom_addr reflects the
//     second line_y. row_buf holds the second row. busy is total 3 cycles.

Source files
------------

// File: rtl/banner_scan_ctrl.sv
// banner_scan_ctrl: per-scanline row fetch from the banner bitmap ROM, a
// registered pixel stream inside the display window, and a per-frame
// horizontal scroll offset with wrap-around.
module banner_scan_ctrl #(
   parameter int WIN_X    = 100,
   parameter int WIN_Y    = 40,
   parameter int WIN_W    = 640,
   parameter int SCALE_SH = 1,
   parameter int ROW_BITS = 1440
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                line_start,
   input  logic [10:0]         line_y,
   input  logic                frame_start,
   input  logic                de,
   input  logic [10:0]         pix_x,
   input  logic                scroll_en,
   input  logic [3:0]          speed,
   input  logic                scroll_clr,
   input  logic [ROW_BITS-1:0] rom_data,
   output logic [5:0]          rom_addr,
   output logic                pixel_on,
   output logic                in_window,
   output logic [10:0]         scroll_pos,
   output logic                busy
);

   localparam int          ROWS  = 41;
   localparam int          IW    = $clog2(ROW_BITS);
   localparam logic [11:0] WX    = 12'(WIN_X);
   localparam logic [11:0] WEND  = 12'(WIN_X + WIN_W);
   localparam logic [11:0] RB    = 12'(ROW_BITS);
   localparam logic [10:0] WY    = 11'(WIN_Y);
   localparam logic [10:0] RMAX  = 11'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, FETCH, LATCH} state_t;

   state_t              state_q, state_d;
   logic [5:0]          rom_addr_q, rom_addr_d;
   logic                busy_q, busy_d;
   logic                row_valid_q, row_valid_d;
   logic [ROW_BITS-1:0] row_buf_q, row_buf_d;
   logic                pixel_on_q, pixel_on_d;
   logic                in_window_q, in_window_d;
   logic [10:0]         scroll_pos_q, scroll_pos_d;

   // Row decode for the incoming line: ROM row r lives at address r+1
   logic [10:0] dy, row_r;
   logic        row_hit;
   assign dy      = line_y - WY;
   assign row_r   = dy >> SCALE_SH;
   assign row_hit = (line_y >= WY) && (row_r <= RMAX);

   // Row-fetch FSM; a new line_start always wins over a fetch in flight
   always_comb begin
      state_d     = state_q;
      rom_addr_d  = rom_addr_q;
      busy_d      = busy_q;
      row_valid_d = row_valid_q;
      row_buf_d   = row_buf_q;
      if (line_start) begin
         row_valid_d = 1'b0;
         if (row_hit) begin
            rom_addr_d = row_r[5:0] + 6'd1;
            busy_d     = 1'b1;
            state_d    = FETCH;
         end else begin
            rom_addr_d = 6'd0;
            busy_d     = 1'b0;
            state_d    = IDLE;
         end
      end else begin
         case (state_q)
            FETCH: state_d = LATCH;
            LATCH: begin
               row_buf_d   = rom_data;
               row_valid_d = 1'b1;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Pixel path: window test plus scrolled bit lookup (leftmost pixel = MSB)
   logic [11:0]   px12, col, s_raw, s_wrap;
   logic [IW-1:0] bit_idx;
   logic          win, bit_val;
   always_comb begin
      px12    = {1'b0, pix_x};
      win     = de && (px12 >= WX) && (px12 < WEND);
      col     = px12 - WX;
      s_raw   = col + {1'b0, scroll_pos_q};
      s_wrap  = (s_raw >= RB) ? (s_raw - RB) : s_raw;
      bit_idx = IW'(ROW_BITS - 1) - s_wrap[IW-1:0];
      // Out-of-window columns can produce out-of-range offsets; mask them
      bit_val = (s_wrap < RB) ? row_buf_q[bit_idx] : 1'b0;
      in_window_d = win;
      pixel_on_d  = win && row_valid_q && bit_val;
   end

   // Scroll offset: clear has priority over the per-frame advance
   logic [11:0] p_sum;
   always_comb begin
      p_sum        = {1'b0, scroll_pos_q} + {8'd0, speed};
      scroll_pos_d = scroll_pos_q;
      if (scroll_clr)
         scroll_pos_d = 11'd0;
      else if (frame_start && scroll_en)
         scroll_pos_d = (p_sum >= RB) ? 11'(p_sum - RB) : p_sum[10:0];
   end

   // State registers; reset discards any partially fetched row
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rom_addr_q   <= '0;
         busy_q       <= 1'b0;
         row_valid_q  <= 1'b0;
         row_buf_q    <= '0;
         pixel_on_q   <= 1'b0;
         in_window_q  <= 1'b0;
         scroll_pos_q <= '0;
      end else begin
         state_q      <= state_d;
         rom_addr_q   <= rom_addr_d;
         busy_q       <= busy_d;
         row_valid_q  <= row_valid_d;
         row_buf_q    <= row_buf_d;
         pixel_on_q   <= pixel_on_d;
         in_window_q  <= in_window_d;
         scroll_pos_q <= scroll_pos_d;
      end
   end

   assign rom_addr   = rom_addr_q;
   assign busy       = busy_q;
   assign pixel_on   = pixel_on_q;
   assign in_window  = in_window_q;
   assign scroll_pos = scroll_pos_q;

endmodule

// File: tb/tb_banner_scan_ctrl.sv
// Scoreboard bench for banner_scan_ctrl: the driver pushes the expected
// post-edge outputs from a behavioural model; a monitor pops and compares.
module tb_banner_scan_ctrl;

   localparam int WIN_X = 100, WIN_Y = 40, WIN_W = 640, SCALE = 2, RB = 1440;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          line_start, frame_start, de, scroll_en, scroll_clr;
   logic [10:0]   line_y, pix_x;
   logic [3:0]    speed;
   logic [RB-1:0] rom_data;
   logic [5:0]    rom_addr;
   logic          pixel_on, in_window, busy;
   logic [10:0]   scroll_pos;

   logic [RB-1:0] rom [0:63];
   assign rom_data = rom[rom_addr];

   always #5 clk = ~clk;

   banner_scan_ctrl dut (
      .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_y(line_y),
      .frame_start(frame_start), .de(de), .pix_x(pix_x), .scroll_en(scroll_en),
      .speed(speed), .scroll_clr(scroll_clr), .rom_data(rom_data),
      .rom_addr(rom_addr), .pixel_on(pixel_on), .in_window(in_window),
      .scroll_pos(scroll_pos), .busy(busy)
   );

   typedef struct packed {
      logic        pix;
      logic        win;
      logic [10:0] sp;
      logic [5:0]  addr;
      logic        busy;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0, n_err = 0;

   // behavioural model state
   logic [RB-1:0] m_row;
   bit            m_valid;
   int            m_scroll, m_addr, m_left;
   bit            m_busy;

   // model one clock edge from the inputs now applied, push the result
   task automatic step();
      exp_t e;
      int   s, r;
      bit   w;
      e = '0;
      if (!rst_n) begin
         m_row = '0; m_valid = 0; m_scroll = 0; m_addr = 0; m_left = 0; m_busy = 0;
      end else begin
         w = de && (pix_x >= WIN_X) && (pix_x < WIN_X + WIN_W);
         e.win = w;
         if (w) begin
            s = (int'(pix_x) - WIN_X + m_scroll) % RB;
            e.pix = m_valid && m_row[RB-1-s];
         end
         if (scroll_clr) m_scroll = 0;
         else if (frame_start && scroll_en) m_scroll = (m_scroll + int'(speed)) % RB;
         if (line_start) begin
            m_valid = 0;
            r = (int'(line_y) - WIN_Y) / SCALE;
            if (int'(line_y) >= WIN_Y && r <= 40) begin
               m_addr = r + 1; m_left = 2; m_busy = 1;
            end else begin
               m_addr = 0; m_left = 0; m_busy = 0;
            end
         end else if (m_left == 2) begin
            m_left = 1;
         end else if (m_left == 1) begin
            m_row = rom[m_addr]; m_valid = 1; m_busy = 0; m_left = 0;
         end
         e.sp = 11'(m_scroll); e.addr = 6'(m_addr); e.busy = m_busy;
      end
      q.push_back(e);
      @(negedge clk);
      line_start = 0; frame_start = 0; scroll_clr = 0;
   endtask

   task automatic idle(input int n);
      de = 0;
      repeat (n) step();
   endtask

   task automatic line(input int y);
      de = 0; line_start = 1; line_y = 11'(y);
      step();
   endtask

   task automatic frame();
      de = 0; frame_start = 1;
      step();
   endtask

   task automatic sweep(input int x0, input int x1);
      for (int x = x0; x <= x1; x++) begin
         de = 1; pix_x = 11'(x);
         step();
      end
      de = 0;
   endtask

   // monitor: compare DUT outputs just after each active edge
   initial begin
      exp_t e, g;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            g = '{pix: pixel_on, win: in_window, sp: scroll_pos, addr: rom_addr, busy: busy};
            n_cmp++;
            if (g !== e) begin
               n_err++;
               $display("FAIL outputs t=%0t pix/win/scroll/addr/busy got %b/%b/%0d/%0d/%b want %b/%b/%0d/%0d/%b",
                        $time, g.pix, g.win, g.sp, g.addr, g.busy, e.pix, e.win, e.sp, e.addr, e.busy);
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int x0, len;
      for (int a = 0; a < 64; a++)
         for (int j = 0; j < RB / 32; j++) rom[a][j*32 +: 32] = $urandom;
      rom[2][RB-1 -: 28] = 28'h0001C18;
      rst_n = 0; line_start = 0; frame_start = 0; de = 0; scroll_en = 0;
      scroll_clr = 0; line_y = 0; pix_x = 0; speed = 0;
      idle(3);
      rst_n = 1;
      idle(2);

      // reset mid-fetch, then no lit pixels until a full fetch completes
      line(60); idle(1);
      rst_n = 0; idle(2); rst_n = 1;
      sweep(95, 110);

      // row decode incl. last row and first line past the banner
      line(40);  idle(4); sweep(98, 120);
      line(121); idle(4); sweep(100, 130);
      line(122); idle(2); sweep(100, 110);

      // full window sweep over ROM row 2 including both edges
      line(42); idle(3); sweep(95, 745);

      // scroll wrap: 96 x 15 = 1440, then 1435 + 7, then frozen
      scroll_en = 1; speed = 15;
      repeat (96) frame();
      scroll_clr = 1; idle(1);
      speed = 5; repeat (287) frame();
      speed = 7; frame();
      speed = 0; repeat (3) frame();

      // clear beats frame_start; disabled scroll holds
      speed = 9; scroll_clr = 1; frame_start = 1; step();
      speed = 4; repeat (5) frame();
      scroll_en = 0; speed = 3; repeat (10) frame();

      // line_start re-pulsed one cycle into a fetch
      line(50); line(70); idle(4); sweep(100, 200);

      // randomized scanlines
      repeat (150) begin
         if ($urandom_range(0, 3) == 0) begin
            speed = 4'($urandom); scroll_en = 1'($urandom);
            scroll_clr = ($urandom_range(0, 9) == 0);
            frame_start = 1;
         end
         line_start = 1; line_y = 11'($urandom_range(30, 135)); de = 0;
         step();
         if ($urandom_range(0, 4) == 0) begin
            idle($urandom_range(0, 1));
            line_start = 1; line_y = 11'($urandom_range(30, 135)); frame_start = ($urandom_range(0, 3) == 0);
            step();
         end
         idle($urandom_range(0, 3));
         x0  = $urandom_range(90, 745);
         len = $urandom_range(1, 120);
         sweep(x0, x0 + len);
         if ($urandom_range(0, 7) == 0) begin
            de = 1; pix_x = 11'($urandom); step(); de = 0;
         end
      end
      idle(3);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expected entries left, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
